btn_event_fifo: RTL

BTN_EVENT_FIFO -- requirements
Module: btn_event_fifo

---
 rtl/btn_pkg.sv | 47 ++++
 rtl/btn_debounce.sv | 69 ++++++
 rtl/btn_event_fifo.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the debounced button event FIFO.
//   - Bit positions of the 32-bit event word presented on rd_data.
//   - Event record stored in each FIFO entry (kind + channel index).
//   - pack_word(): builds the rd_data word for a valid head entry.
// -----------------------------------------------------------------------------
package btn_pkg;

  // rd_data field positions
  localparam int VALID_BIT = 31;
  localparam int OVF_BIT   = 30;
  localparam int COUNT_LSB = 16;
  localparam int COUNT_W   = 8;
  localparam int REL_BIT   = 8;
  localparam int IDX_MSB   = 4;
  localparam int IDX_W     = IDX_MSB + 1;

  // Kind of event held in a FIFO entry
  typedef enum logic {
    EVT_PRESS   = 1'b0,
    EVT_RELEASE = 1'b1
  } evt_kind_e;

  // One FIFO entry
  typedef struct packed {
    evt_kind_e        kind;
    logic [IDX_W-1:0] idx;
  } evt_t;

  // Assemble the event word for a non-empty FIFO; unused bits stay zero.
  function automatic logic [31:0] pack_word(
    input logic               ovf,
    input logic [COUNT_W-1:0] cnt,
    input evt_t               evt
  );
    logic [31:0] word;
    word                          = 32'h0000_0000;
    word[VALID_BIT]               = 1'b1;
    word[OVF_BIT]                 = ovf;
    word[COUNT_LSB +: COUNT_W]    = cnt;
    word[REL_BIT]                 = (evt.kind == EVT_RELEASE) ? 1'b1 : 1'b0;
    word[IDX_MSB:0]               = evt.idx;
    return word;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One button channel: 2-flop synchroniser followed by a stability counter.
// The debounced level flips only after the synchronised input has disagreed
// with it for DEBOUNCE_CYCLES consecutive clocks; any agreement in between
// restarts the count from zero.
//
// Ports
//   clock     in   single clock
//   reset_n   in   asynchronous active-low reset (level returns to 0)
//   btn_async in   raw asynchronous button level, active-high
//   level     out  current debounced level (registered)
//   change    out  high in the cycle whose rising edge flips 'level';
//                  decoded from registers only, so it is glitch-free
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_async,
  output logic level,
  output logic change
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;
  logic          differ_s;

  // Two-stage synchroniser for the asynchronous button input
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_async;
      sync2_r <= sync1_r;
    end
  end

  assign differ_s = (sync2_r != level_r);

  // Stability counter; the count reaching CNT_MAX while still differing
  // means this is the DEBOUNCE_CYCLES-th consecutive differing cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else if (differ_s) begin
      if (cnt_r == CNT_MAX) begin
        level_r <= sync2_r;
        cnt_r   <= '0;
      end else begin
        cnt_r   <= cnt_r + 1'b1;
      end
    end else begin
      cnt_r <= '0;
    end
  end

  assign level  = level_r;
  assign change = differ_s & (cnt_r == CNT_MAX);

endmodule

// File: rtl/btn_event_fifo.sv
// -----------------------------------------------------------------------------
// btn_event_fifo
// Debounces NUM_BTN button inputs and queues press events (and, optionally,
// release events) in a DEPTH-entry show-ahead FIFO read through a single
// 32-bit MMIO-style word.
//
// Optional feature: define BTN_RELEASE_EVT_EN to also queue release events
// (rd_data[8]=1). Without it only press events are generated.
//
// Ports
//   clock    in   single clock
//   reset_n  in   asynchronous active-low reset
//   btn_in   in   raw button levels [NUM_BTN-1:0], active-high
//   rd_en    in   pop strobe; ignored while empty
//   clr      in   synchronous flush of FIFO, pending events and overflow
//   rd_data  out  head event word: [31] valid, [30] overflow,
//                 [23:16] entry count, [8] release, [4:0] channel; 0 if empty
//   empty    out  FIFO holds no entries
//   full     out  FIFO holds DEPTH entries
//   overflow out  sticky: an event was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module btn_event_fifo
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEPTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic               rd_en,
  input  logic               clr,
  output logic [31:0]        rd_data,
  output logic               empty,
  output logic               full,
  output logic               overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Debounced levels and one-cycle change strobes per channel
  logic [NUM_BTN-1:0] level_s;
  logic [NUM_BTN-1:0] change_s;
  logic [NUM_BTN-1:0] press_s;
  logic [NUM_BTN-1:0] press_pend_r;
  logic [NUM_BTN-1:0] press_cand_s;
  logic [NUM_BTN-1:0] press_take_s;
`ifdef BTN_RELEASE_EVT_EN
  logic [NUM_BTN-1:0] rel_s;
  logic [NUM_BTN-1:0] rel_pend_r;
  logic [NUM_BTN-1:0] rel_cand_s;
  logic [NUM_BTN-1:0] rel_take_s;
`endif

  // FIFO state
  evt_t              mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              overflow_r;

  logic              empty_s;
  logic              full_s;
  logic              pop_s;
  logic              sel_valid_s;
  evt_t              sel_evt_s;
  logic              push_s;
  logic              drop_s;
  evt_t              head_evt_s;
  logic [COUNT_W-1:0] count8_s;

  // Per-channel synchroniser + debounce
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clock     (clock),
      .reset_n   (reset_n),
      .btn_async (btn_in[g]),
      .level     (level_s[g]),
      .change    (change_s[g])
    );
  end

  // 'level' still holds the old value while 'change' is high, so a change
  // from 0 is a press and a change from 1 is a release.
  assign press_s      = change_s & ~level_s;
  assign press_cand_s = press_pend_r | press_s;
`ifdef BTN_RELEASE_EVT_EN
  assign rel_s        = change_s & level_s;
  assign rel_cand_s   = rel_pend_r | rel_s;
`endif

  assign empty_s = (count_r == '0);
  assign full_s  = (count_r == CW'(DEPTH));
  assign pop_s   = rd_en & ~empty_s;

  // Priority pick of the single event to push this cycle. Scanning from the
  // top down lets the lowest index win; press beats release on one channel.
  always_comb begin
    sel_valid_s  = 1'b0;
    sel_evt_s    = '{kind: EVT_PRESS, idx: '0};
    press_take_s = '0;
`ifdef BTN_RELEASE_EVT_EN
    rel_take_s   = '0;
`endif
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (press_cand_s[i]) begin
        sel_valid_s     = 1'b1;
        sel_evt_s       = '{kind: EVT_PRESS, idx: IDX_W'(i)};
        press_take_s    = '0;
        press_take_s[i] = 1'b1;
`ifdef BTN_RELEASE_EVT_EN
        rel_take_s      = '0;
`endif
      end
`ifdef BTN_RELEASE_EVT_EN
      else if (rel_cand_s[i]) begin
        sel_valid_s   = 1'b1;
        sel_evt_s     = '{kind: EVT_RELEASE, idx: IDX_W'(i)};
        press_take_s  = '0;
        rel_take_s    = '0;
        rel_take_s[i] = 1'b1;
      end
`endif
      else begin
      end
    end
  end

  // A full FIFO still accepts a push when the same edge pops an entry.
  assign push_s = sel_valid_s & (~full_s | pop_s);
  assign drop_s = sel_valid_s & full_s & ~pop_s;

  // Pending bits: set by new events (coalescing repeats), cleared when the
  // selected event is either pushed or dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      press_pend_r <= '0;
    end else if (clr) begin
      press_pend_r <= '0;
    end else begin
      press_pend_r <= press_cand_s & ~press_take_s;
    end
  end

`ifdef BTN_RELEASE_EVT_EN
  // Release pending bits, kept separately from the press bits
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rel_pend_r <= '0;
    end else if (clr) begin
      rel_pend_r <= '0;
    end else begin
      rel_pend_r <= rel_cand_s & ~rel_take_s;
    end
  end
`endif

  // Entry storage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{kind: EVT_PRESS, idx: '0};
      end
    end else if (push_s && !clr) begin
      mem_r[wr_ptr_r] <= sel_evt_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers, occupancy and sticky overflow; clr overrides push/pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else if (clr) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Show-ahead head word; all-zero while the FIFO is empty
  assign head_evt_s = mem_r[rd_ptr_r];
  assign count8_s   = COUNT_W'(count_r);

  always_comb begin
    if (empty_s) begin
      rd_data = 32'h0000_0000;
    end else begin
      rd_data = pack_word(overflow_r, count8_s, head_evt_s);
    end
  end

  assign empty    = empty_s;
  assign full     = full_s;
  assign overflow = overflow_r;

endmodule
